// File: rtl/pmem_arbiter_if.sv
// Signal bundle between the I/D caches, the shared pmem port and pmem_arbiter.
// slave = the arbiter; master = the caches together with the pmem device.
interface pmem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 128
);
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  i_read, i_address,
    output i_rdata, i_resp,
    input  d_read, d_write, d_address, d_wdata,
    output d_rdata, d_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output i_read, i_address,
    input  i_rdata, i_resp,
    output d_read, d_write, d_address, d_wdata,
    input  d_rdata, d_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/pmem_arbiter.sv
// Arbitrates the single pmem port between I-cache fills and D-cache fills/writebacks.
// Optional ARB_STARVE_GUARD_EN lets I win after MAX_D_STREAK consecutive D grants.
module pmem_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 128
`ifdef ARB_STARVE_GUARD_EN
  , parameter int unsigned MAX_D_STREAK = 4
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  pmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              pmem_read_q, pmem_read_d;
  logic              pmem_write_q, pmem_write_d;
  logic [ADDR_W-1:0] pmem_address_q, pmem_address_d;
  logic [LINE_W-1:0] pmem_wdata_q, pmem_wdata_d;
  logic              d_req;
  logic              i_wins;

  assign d_req = bus.d_read | bus.d_write;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned STREAK_W = 3;
  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MAX_D_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_SAT   = '1;

  logic [STREAK_W-1:0] streak_q, streak_d;

  assign i_wins = bus.i_read & (~d_req | (streak_q == STREAK_LIMIT));

  // Counts D grants made over a pending I request; any I grant or absent I request clears it.
  always_comb begin
    streak_d = streak_q;
    if (state_q == IDLE) begin
      if (!bus.i_read || i_wins) begin
        streak_d = '0;
      end else if (d_req && (streak_q != STREAK_SAT)) begin
        streak_d = streak_q + STREAK_W'(1);
      end
    end
  end
`else
  assign i_wins = bus.i_read & ~d_req;
`endif

  always_comb begin
    state_d        = state_q;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    case (state_q)
      IDLE: begin
        if (i_wins) begin
          state_d        = SERVE_I;
          pmem_read_d    = 1'b1;
          pmem_address_d = bus.i_address;
        end else if (d_req) begin
          state_d        = SERVE_D;
          pmem_address_d = bus.d_address;
          // Read+write together is a writeback; the fill comes back as a later request.
          if (bus.d_write) begin
            pmem_write_d = 1'b1;
            pmem_wdata_d = bus.d_wdata;
          end else begin
            pmem_read_d  = 1'b1;
          end
        end
      end
      SERVE_I, SERVE_D: begin
        if (bus.pmem_resp) begin
          state_d      = DONE;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
`ifdef ARB_STARVE_GUARD_EN
      streak_q       <= '0;
`endif
    end else begin
      state_q        <= state_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
`ifdef ARB_STARVE_GUARD_EN
      streak_q       <= streak_d;
`endif
    end
  end

  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_write   = pmem_write_q;
  assign bus.pmem_address = pmem_address_q;
  assign bus.pmem_wdata   = pmem_wdata_q;

  // Completion is forwarded in the same cycle pmem answers, only to the side being served.
  assign bus.i_resp  = (state_q == SERVE_I) & bus.pmem_resp;
  assign bus.d_resp  = (state_q == SERVE_D) & bus.pmem_resp;
  assign bus.i_rdata = bus.pmem_rdata;
  assign bus.d_rdata = bus.pmem_rdata;
endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: directed table, hand sequences, and random traffic
// against a cycle-count/ordering model plus a reference line memory.
module tb_pmem_arbiter;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned LINE_W = 128;
`ifdef ARB_STARVE_GUARD_EN
  localparam int EXP_STREAK_D = 4;
  localparam int EXP_STREAK_I = 1;
`else
  localparam int EXP_STREAK_D = 10;
  localparam int EXP_STREAK_I = 0;
`endif

  typedef struct {
    bit                ir;
    bit                dr;
    bit                dw;
    logic [ADDR_W-1:0] ia;
    logic [ADDR_W-1:0] da;
    logic [LINE_W-1:0] wd;
    int                lat;
    bit                scr;
    bit                spur;
    int                exp_d;
    int                exp_i;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  pmem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total;
  int bad;
  int lat;
  bit spur_en;
  int busy;
  logic [LINE_W-1:0] mem     [logic [ADDR_W-1:0]];
  logic [LINE_W-1:0] ref_mem [logic [ADDR_W-1:0]];

  logic              s_pr, s_pw, s_ir, s_dr;
  logic [ADDR_W-1:0] s_addr;
  logic [LINE_W-1:0] s_wdata, s_irdata, s_drdata;

  function automatic logic [LINE_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return {8{a ^ 16'h5A5A}};
  endfunction

  function automatic logic [LINE_W-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [LINE_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pat(a);
  endfunction

  // D wins a tie; first resp at 1+lat, the loser starts after DONE and the IDLE decision.
  function automatic void model_times(input vec_t v, output int ed, output int ei);
    int first;
    first = 1 + v.lat;
    ed = -1;
    ei = -1;
    if ((v.dr || v.dw) && v.ir) begin
      ed = first;
      ei = first + 3 + v.lat;
    end else if (v.dr || v.dw) begin
      ed = first;
    end else if (v.ir) begin
      ei = first;
    end
  endfunction

  // pmem device: answers after 'lat' cycles of strobe, optional stray pulse when idle
  initial begin
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    busy = 0;
    forever begin
      @(posedge clk);
      #2;
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = rnd_line();
      if (!rst_n) begin
        busy = 0;
      end else if (bus.pmem_read || bus.pmem_write) begin
        if (busy == lat) begin
          busy = 0;
          bus.pmem_resp = 1'b1;
          if (bus.pmem_write) mem[bus.pmem_address] = bus.pmem_wdata;
          else bus.pmem_rdata = mem.exists(bus.pmem_address) ? mem[bus.pmem_address]
                                                             : pat(bus.pmem_address);
        end else begin
          busy++;
        end
      end else begin
        busy = 0;
        bus.pmem_resp = spur_en;
      end
    end
  end

  task automatic check_v(input string name, input logic [LINE_W-1:0] act,
                         input logic [LINE_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Sample the current cycle at negedge, then advance to just after the next posedge.
  task automatic cyc();
    @(negedge clk);
    s_pr     = bus.pmem_read;
    s_pw     = bus.pmem_write;
    s_ir     = bus.i_resp;
    s_dr     = bus.d_resp;
    s_addr   = bus.pmem_address;
    s_wdata  = bus.pmem_wdata;
    s_irdata = bus.i_rdata;
    s_drdata = bus.d_rdata;
    check_v("strobe_excl", LINE_W'(s_pr & s_pw), '0);
    check_v("resp_excl", LINE_W'(s_ir & s_dr), '0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int d_at, i_at, d_cnt, i_cnt, ntx, nexp, last;
    int st_cyc[2];
    bit st_w[2];
    logic [ADDR_W-1:0] st_a[2];
    logic [LINE_W-1:0] st_wd[2];
    int ex_start[2];
    bit ex_w[2];
    logic [ADDR_W-1:0] ex_a[2];
    logic [LINE_W-1:0] ex_wd[2];
    logic [LINE_W-1:0] d_data, i_data, exp_dd, exp_id;
    bit prev, unstable, d_first, dq, take_d;

    dq      = v.dr | v.dw;
    d_first = dq && (!v.ir || (v.exp_d < v.exp_i));
    nexp = 0; exp_dd = '0; exp_id = '0;
    for (int k = 0; k < 2; k++) begin
      take_d = (k == 0) ? d_first : !d_first;
      if (take_d && dq) begin
        ex_start[nexp] = v.exp_d - v.lat; ex_w[nexp] = v.dw;
        ex_a[nexp] = v.da; ex_wd[nexp] = v.wd;
        if (v.dw) ref_mem[v.da] = v.wd;
        else exp_dd = ref_rd(v.da);
        nexp++;
      end else if (!take_d && v.ir) begin
        ex_start[nexp] = v.exp_i - v.lat; ex_w[nexp] = 1'b0;
        ex_a[nexp] = v.ia; ex_wd[nexp] = '0;
        exp_id = ref_rd(v.ia);
        nexp++;
      end
    end

    lat = v.lat;
    bus.i_read = v.ir; bus.d_read = v.dr; bus.d_write = v.dw;
    bus.i_address = v.ia; bus.d_address = v.da; bus.d_wdata = v.wd;
    d_at = -1; i_at = -1; d_cnt = 0; i_cnt = 0; ntx = 0;
    prev = 1'b0; unstable = 1'b0; d_data = '0; i_data = '0;
    last = (v.exp_d > v.exp_i) ? v.exp_d : v.exp_i;

    for (int c = 0; c <= last + 2; c++) begin
      cyc();
      if ((s_pr | s_pw) && !prev) begin
        if (ntx < 2) begin
          st_cyc[ntx] = c; st_w[ntx] = s_pw; st_a[ntx] = s_addr; st_wd[ntx] = s_wdata;
        end
        ntx++;
      end else if ((s_pr | s_pw) && (ntx > 0) && (ntx <= 2)) begin
        if ((s_addr !== st_a[ntx-1]) || (s_wdata !== st_wd[ntx-1])) unstable = 1'b1;
      end
      prev = s_pr | s_pw;
      if (s_dr) begin
        d_cnt++;
        if (d_cnt == 1) begin d_at = c; d_data = s_drdata; end
        bus.d_read = 1'b0; bus.d_write = 1'b0;
      end
      if (s_ir) begin
        i_cnt++;
        if (i_cnt == 1) begin i_at = c; i_data = s_irdata; end
        bus.i_read = 1'b0;
      end
      spur_en = v.spur & (s_dr | s_ir);
      // Disturb the served side's inputs; only the latched copy may reach pmem.
      if (v.scr && prev && ((d_first && d_cnt == 0) || (!d_first && i_cnt == 0))) begin
        if (d_first) begin
          bus.d_address = ADDR_W'($urandom);
          bus.d_wdata   = rnd_line();
        end else begin
          bus.i_address = ADDR_W'($urandom);
        end
      end
    end
    spur_en = 1'b0;
    bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
    cyc();
    cyc();

    check_i({tag, "_d_resp_cyc"}, d_at, v.exp_d);
    check_i({tag, "_i_resp_cyc"}, i_at, v.exp_i);
    check_i({tag, "_d_resp_cnt"}, d_cnt, dq ? 1 : 0);
    check_i({tag, "_i_resp_cnt"}, i_cnt, v.ir ? 1 : 0);
    check_i({tag, "_txn_cnt"}, ntx, nexp);
    for (int k = 0; k < 2; k++) begin
      if (k < nexp && k < ntx) begin
        check_i({tag, "_strobe_cyc"}, st_cyc[k], ex_start[k]);
        check_i({tag, "_op_write"}, int'(st_w[k]), int'(ex_w[k]));
        check_v({tag, "_addr"}, LINE_W'(st_a[k]), LINE_W'(ex_a[k]));
        if (ex_w[k]) check_v({tag, "_wdata"}, st_wd[k], ex_wd[k]);
      end
    end
    check_i({tag, "_stable"}, int'(unstable), 0);
    if (v.dr && !v.dw) check_v({tag, "_d_rdata"}, d_data, exp_dd);
    if (v.ir) check_v({tag, "_i_rdata"}, i_data, exp_id);
  endtask

  vec_t tbl[8];
  vec_t rv;
  int nd, ni;

  initial begin
    total = 0; bad = 0; lat = 1; spur_en = 1'b0;
    rst_n = 1'b0;
    bus.i_read = 1'b0; bus.i_address = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0;

    // ir dr dw ia da wd lat scr spur exp_d exp_i
    tbl[0] = '{1'b1, 1'b0, 1'b0, 16'h1230, 16'h0000, 128'h0, 3, 1'b0, 1'b0, -1, 4};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h2000, 128'h0, 1, 1'b0, 1'b0, 2, -1};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h4000, {16{8'hA5}}, 2, 1'b1, 1'b0, 3, -1};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 16'h1230, 16'h4000, 128'h0, 2, 1'b0, 1'b1, 3, 8};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0100, {16{8'h5A}}, 1, 1'b1, 1'b0, 2, -1};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 128'h0, 4, 1'b0, 1'b0, -1, 5};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 16'h0010, 16'h0010, {16{8'hC3}}, 1, 1'b0, 1'b1, 2, 6};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 16'h0777, 16'h0000, 128'h0, 2, 1'b1, 1'b1, -1, 3};

    @(posedge clk);
    #1;
    cyc();
    check_v("rst_pmem_read", LINE_W'(s_pr), '0);
    check_v("rst_pmem_write", LINE_W'(s_pw), '0);
    check_v("rst_pmem_address", LINE_W'(s_addr), '0);
    check_v("rst_pmem_wdata", s_wdata, '0);
    check_v("rst_i_resp", LINE_W'(s_ir), '0);
    check_v("rst_d_resp", LINE_W'(s_dr), '0);
    rst_n = 1'b1;
    cyc();
    cyc();

    // stray pmem_resp while idle must not respond or leave IDLE
    spur_en = 1'b1;
    cyc();
    check_v("spur_idle_i_resp", LINE_W'(s_ir), '0);
    check_v("spur_idle_d_resp", LINE_W'(s_dr), '0);
    spur_en = 1'b0;
    cyc();
    check_v("spur_idle_strobe", LINE_W'(s_pr | s_pw), '0);

    for (int k = 0; k < 8; k++) run_vec(tbl[k], $sformatf("tbl%0d", k));

    // reset in the middle of a D read
    lat = 20;
    bus.d_read = 1'b1; bus.d_address = 16'h3000;
    cyc(); cyc(); cyc();
    check_v("mid_serve_strobe", LINE_W'(s_pr), LINE_W'(1'b1));
    rst_n = 1'b0;
    #1;
    check_v("async_rst_read", LINE_W'(bus.pmem_read), '0);
    check_v("async_rst_write", LINE_W'(bus.pmem_write), '0);
    check_v("async_rst_addr", LINE_W'(bus.pmem_address), '0);
    check_v("async_rst_d_resp", LINE_W'(bus.d_resp), '0);
    bus.d_read = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    rv = '{1'b1, 1'b0, 1'b0, 16'h0550, 16'h0000, 128'h0, 2, 1'b0, 1'b0, -1, 3};
    run_vec(rv, "post_rst");

    // continuous D traffic with I pending
    lat = 1;
    bus.i_read = 1'b1; bus.i_address = 16'h0800;
    bus.d_read = 1'b1; bus.d_address = 16'h0900;
    nd = 0; ni = 0;
    for (int c = 0; c < 40 && ni == 0; c++) begin
      cyc();
      if (s_dr) nd++;
      if (s_ir) ni++;
    end
    bus.i_read = 1'b0; bus.d_read = 1'b0;
    cyc(); cyc(); cyc();
    check_i("streak_d_grants", nd, EXP_STREAK_D);
    check_i("streak_i_grant", ni, EXP_STREAK_I);

    for (int n = 0; n < 30; n++) begin
      rv.ir = 1'($urandom);
      rv.dr = 1'($urandom);
      rv.dw = 1'($urandom);
      if (!rv.ir && !rv.dr && !rv.dw) rv.ir = 1'b1;
      rv.ia   = ADDR_W'($urandom_range(0, 7) << 4);
      rv.da   = ADDR_W'($urandom_range(0, 7) << 4);
      rv.wd   = rnd_line();
      rv.lat  = int'($urandom_range(1, 4));
      rv.scr  = 1'($urandom);
      rv.spur = 1'($urandom);
      model_times(rv, rv.exp_d, rv.exp_i);
      run_vec(rv, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
